// File: rtl/apb_alu_master.sv
// apb_alu_master
// APB3 initiator that drives the ALU CSR slave from a command port. For each
// accepted command it writes DATA_0 and DATA_1, writes CTRL with the start
// bit set, polls STATUS until the output FIFO is non-empty, and then reads
// RESULT. The result, or an error, is returned on a response port.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd_*             command port (valid/ready), operands, opcode, id
//   rsp_*             response port (valid/ready), result data, error flag
//   paddr..pwdata     APB3 request outputs
//   prdata, pready,
//   pslverr           APB3 completion inputs
//
// Handshakes: a transfer on the cmd or rsp port happens on a rising clock
// edge where valid and ready are both 1. The producer keeps valid and the
// payload stable until that edge, and ready never depends on valid.
module apb_alu_master #(
  parameter int APB_BUS_SIZE   = 32,
  parameter int DATA_SIZE      = 16,
  parameter int ID_SIZE        = 8,
  parameter int OPERATION_SIZE = 2,
  parameter int FIFO_OUT_WIDTH = 25,
  parameter int POLL_MAX       = 255,
  parameter logic [APB_BUS_SIZE-1:0] ADDR_CTRL   = 'h00,
  parameter logic [APB_BUS_SIZE-1:0] ADDR_DATA0  = 'h04,
  parameter logic [APB_BUS_SIZE-1:0] ADDR_DATA1  = 'h08,
  parameter logic [APB_BUS_SIZE-1:0] ADDR_RESULT = 'h0C,
  parameter logic [APB_BUS_SIZE-1:0] ADDR_STATUS = 'h10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [OPERATION_SIZE-1:0] cmd_op,
  input  logic [ID_SIZE-1:0]        cmd_id,
  input  logic [DATA_SIZE-1:0]      cmd_a,
  input  logic [DATA_SIZE-1:0]      cmd_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [FIFO_OUT_WIDTH-1:0] rsp_data,
  output logic                      rsp_err,
  output logic [APB_BUS_SIZE-1:0]   paddr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [APB_BUS_SIZE-1:0]   pwdata,
  input  logic [APB_BUS_SIZE-1:0]   prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int POLL_W = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, W_D0, W_D1, W_CTRL, R_STAT, POLL_GAP, R_RES, RESP
  } state_t;

  state_t                      state_q, state_d;
  logic                        access_q, access_d;   // 0 = SETUP, 1 = ACCESS
  logic [POLL_W-1:0]           poll_q, poll_d;
  logic [OPERATION_SIZE-1:0]   op_q;
  logic [ID_SIZE-1:0]          id_q;
  logic [DATA_SIZE-1:0]        a_q, b_q;
  logic [FIFO_OUT_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                        rsp_err_q, rsp_err_d;
  logic                        cmd_fire;
  logic                        bus_state;
  logic [APB_BUS_SIZE-1:0]     ctrl_word;
  logic                        unused_prdata;

  // Only the RESULT field and the STATUS empty bit are consumed.
  assign unused_prdata = ^prdata[APB_BUS_SIZE-1:FIFO_OUT_WIDTH];

  assign cmd_ready = (state_q == IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  assign bus_state = (state_q == W_D0) || (state_q == W_D1) || (state_q == W_CTRL) ||
                     (state_q == R_STAT) || (state_q == R_RES);

  // APB request outputs are decoded from registered state, so an
  // asynchronous reset drops them on the same instant.
  assign psel    = bus_state;
  assign penable = bus_state && access_q;
  assign pwrite  = (state_q == W_D0) || (state_q == W_D1) || (state_q == W_CTRL);

  always_comb begin
    ctrl_word                        = '0;
    ctrl_word[0]                     = 1'b1;
    ctrl_word[1 +: OPERATION_SIZE]   = op_q;
    ctrl_word[8 +: ID_SIZE]          = id_q;
  end

  always_comb begin
    paddr  = '0;
    pwdata = '0;
    case (state_q)
      W_D0:   begin paddr = ADDR_DATA0;  pwdata = APB_BUS_SIZE'(a_q); end
      W_D1:   begin paddr = ADDR_DATA1;  pwdata = APB_BUS_SIZE'(b_q); end
      W_CTRL: begin paddr = ADDR_CTRL;   pwdata = ctrl_word;          end
      R_STAT: paddr = ADDR_STATUS;
      R_RES:  paddr = ADDR_RESULT;
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    access_d   = access_q;
    poll_d     = poll_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d  = W_D0;
          access_d = 1'b0;
        end
      end
      POLL_GAP: begin
        state_d  = R_STAT;
        access_d = 1'b0;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          poll_d  = '0;
        end
      end
      default: begin
        // Bus states: one SETUP cycle, then ACCESS until the slave is ready.
        if (!access_q) begin
          access_d = 1'b1;
        end else if (pready) begin
          access_d = 1'b0;
          if (pslverr) begin
            state_d    = RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else begin
            case (state_q)
              W_D0:   state_d = W_D1;
              W_D1:   state_d = W_CTRL;
              W_CTRL: state_d = R_STAT;
              R_STAT: begin
                if (!prdata[0]) begin
                  state_d = R_RES;
                end else if (int'(poll_q) + 1 < POLL_MAX) begin
                  poll_d  = poll_q + POLL_W'(1);
                  state_d = POLL_GAP;
                end else begin
                  // Out of polls: report a timeout as an error.
                  state_d    = RESP;
                  rsp_err_d  = 1'b1;
                  rsp_data_d = '0;
                end
              end
              R_RES: begin
                state_d    = RESP;
                rsp_err_d  = 1'b0;
                rsp_data_d = prdata[FIFO_OUT_WIDTH-1:0];
              end
              default: state_d = IDLE;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      access_q   <= 1'b0;
      poll_q     <= '0;
      op_q       <= '0;
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      access_q   <= access_d;
      poll_q     <= poll_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      if (cmd_fire) begin
        op_q <= cmd_op;
        id_q <= cmd_id;
        a_q  <= cmd_a;
        b_q  <= cmd_b;
      end
    end
  end

endmodule

// File: tb/tb_apb_alu_master.sv
// Testbench for apb_alu_master: APB slave model, command driver, response
// monitor with an expected queue, and a final report.
module tb_apb_alu_master;

  localparam int AW = 32;
  localparam int DW = 16;
  localparam int IW = 8;
  localparam int OW = 2;
  localparam int RW = 25;
  localparam int POLL_MAX = 4;
  localparam int NO_ERR = 99;
  localparam logic [AW-1:0] ADDR_CTRL   = 32'h00;
  localparam logic [AW-1:0] ADDR_DATA0  = 32'h04;
  localparam logic [AW-1:0] ADDR_DATA1  = 32'h08;
  localparam logic [AW-1:0] ADDR_RESULT = 32'h0C;
  localparam logic [AW-1:0] ADDR_STATUS = 32'h10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [OW-1:0] cmd_op = '0;
  logic [IW-1:0] cmd_id = '0;
  logic [DW-1:0] cmd_a = '0;
  logic [DW-1:0] cmd_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [RW-1:0] rsp_data;
  logic          rsp_err;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite;
  logic [AW-1:0] pwdata;
  logic [AW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  apb_alu_master #(.POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_id(cmd_id),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // ---------------- scoreboard state ----------------
  logic [RW:0]   exp_q[$];      // {err, data}
  logic [2*AW:0] bus_q[$];      // {write, addr, wdata}
  int            lat_q[$];
  int            hold_q[$];
  int            acc_q[$];
  int            outstanding = 0;
  int            checks = 0;
  int            failures = 0;

  // slave behaviour for the command in flight
  int            cfg_wait = 0;
  int            cfg_n_empty = 0;
  int            cfg_err_idx = NO_ERR;
  logic [RW-1:0] cfg_result = '0;
  int            xfer_idx = 0;
  int            status_reads = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic clear_expectations();
    exp_q.delete(); bus_q.delete(); lat_q.delete(); hold_q.delete(); acc_q.delete();
    outstanding = 0;
  endtask

  // ---------------- APB slave model + bus checker ----------------
  logic          in_access = 1'b0;
  logic [AW-1:0] cap_addr, cap_wdata;
  logic          cap_write;
  int            wcnt = 0;

  always @(negedge clk) begin
    logic [2*AW:0] e;
    if (rst_n && psel && penable) begin
      if (!in_access) begin
        in_access = 1'b1;
        wcnt = 0;
        cap_addr = paddr; cap_wdata = pwdata; cap_write = pwrite;
      end else begin
        check("access_addr_stable", {pwrite, paddr}, {cap_write, cap_addr});
        check("access_wdata_stable", pwdata, cap_wdata);
      end
      if (wcnt < cfg_wait) begin
        wcnt++;
        pready  = 1'b0;
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
      end else begin
        pready    = 1'b1;
        in_access = 1'b0;
        pslverr   = (xfer_idx == cfg_err_idx);
        prdata    = $urandom;
        if (!pwrite && paddr == ADDR_STATUS) begin
          status_reads++;
          prdata = (status_reads <= cfg_n_empty) ? 32'h1 : 32'h2;
        end else if (!pwrite && paddr == ADDR_RESULT) begin
          prdata = {7'($urandom), cfg_result};
        end
        if (bus_q.size() == 0) begin
          flag_fail("unexpected_apb_transfer");
        end else begin
          e = bus_q.pop_front();
          check("xfer_write_addr", {pwrite, paddr}, e[2*AW:AW]);
          if (pwrite) check("xfer_wdata", pwdata, e[AW-1:0]);
        end
        xfer_idx++;
      end
    end else begin
      in_access = 1'b0;
      pready    = 1'($urandom_range(0, 1));
      pslverr   = 1'($urandom_range(0, 1));
      prdata    = $urandom;
    end
  end

  // ---------------- response monitor ----------------
  logic        rsp_seen = 1'b0;
  int          hold_cnt = 0;
  logic [RW:0] cur_exp = '0;

  always @(negedge clk) begin
    int acc, lat;
    if (rst_n && rsp_valid) begin
      if (!rsp_seen) begin
        rsp_seen = 1'b1;
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          flag_fail("unexpected_response");
          cur_exp  = '0;
          hold_cnt = 0;
        end else begin
          cur_exp  = exp_q.pop_front();
          hold_cnt = hold_q.pop_front();
          acc      = acc_q.pop_front();
          lat      = lat_q.pop_front();
          check("rsp_latency", 128'(cyc - acc), 128'(lat));
        end
      end
      check("rsp_data", rsp_data, cur_exp[RW-1:0]);
      check("rsp_err", rsp_err, cur_exp[RW]);
      check("cmd_ready_while_resp", cmd_ready, 1'b0);
      if (hold_cnt > 0) begin
        hold_cnt--;
        rsp_ready = 1'b0;
      end else begin
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
      end
    end else begin
      if (rsp_seen) begin
        rsp_seen = 1'b0;
        outstanding--;
      end
      rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver + reference model ----------------
  // Builds the expected bus sequence and response from the command rules,
  // then offers the command and waits for its response to be consumed.
  task automatic issue_cmd(input logic [OW-1:0] op, input logic [IW-1:0] id,
                           input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input int wt, input int ne, input int ei, input int hold,
                           input bit keep, input logic [RW-1:0] res);
    logic [2*AW:0] xf[$];
    logic [AW-1:0] ctrl;
    logic [RW:0]   rsp;
    bit            timeout;
    int            sr, lat, budget, nreads;
    ctrl = 32'(id) * 256 + 32'(op) * 2 + 1;
    xf.push_back({1'b1, ADDR_DATA0, 32'(a)});
    xf.push_back({1'b1, ADDR_DATA1, 32'(b)});
    xf.push_back({1'b1, ADDR_CTRL, ctrl});
    timeout = (ne >= POLL_MAX);
    nreads  = timeout ? POLL_MAX : ne + 1;
    for (int i = 0; i < nreads; i++) xf.push_back({1'b0, ADDR_STATUS, 32'h0});
    if (!timeout) xf.push_back({1'b0, ADDR_RESULT, 32'h0});
    if (ei < xf.size()) begin
      while (xf.size() > ei + 1) void'(xf.pop_back());
      rsp = {1'b1, {RW{1'b0}}};
    end else if (timeout) begin
      rsp = {1'b1, {RW{1'b0}}};
    end else begin
      rsp = {1'b0, res};
    end
    sr = 0;
    foreach (xf[i]) if (!xf[i][2*AW] && xf[i][2*AW-1:AW] == ADDR_STATUS) sr++;
    lat = 1 + xf.size() * (2 + wt) + ((sr > 0) ? sr - 1 : 0);

    cfg_wait = wt; cfg_n_empty = ne; cfg_err_idx = ei; cfg_result = res;
    xfer_idx = 0; status_reads = 0;
    foreach (xf[i]) bus_q.push_back(xf[i]);
    exp_q.push_back(rsp);
    lat_q.push_back(lat);
    hold_q.push_back(hold);
    outstanding++;

    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_id = id; cmd_a = a; cmd_b = b;
    budget = 0;
    while (!cmd_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!cmd_ready) begin
      flag_fail("cmd_accept_timeout");
      cmd_valid = 1'b0;
      clear_expectations();
      return;
    end
    acc_q.push_back(cyc);
    @(posedge clk);
    #1;
    if (!keep) cmd_valid = 1'b0;
    // Scramble the payload: the design must have latched it.
    cmd_op = OW'($urandom); cmd_id = IW'($urandom);
    cmd_a = DW'($urandom); cmd_b = DW'($urandom);
    budget = 0;
    while (outstanding > 0 && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    if (outstanding > 0) begin
      flag_fail("rsp_timeout");
      cmd_valid = 1'b0;
      clear_expectations();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ei;
    #12;
    check("reset_psel", psel, 1'b0);
    check("reset_penable", penable, 1'b0);
    check("reset_pwrite", pwrite, 1'b0);
    check("reset_paddr", paddr, 32'h0);
    check("reset_pwdata", pwdata, 32'h0);
    check("reset_cmd_ready", cmd_ready, 1'b1);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_err", rsp_err, 1'b0);
    check("reset_rsp_data", rsp_data, 25'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic transaction, zero wait states
    issue_cmd(2'd2, 8'h5A, 16'h1234, 16'h00FF, 0, 0, NO_ERR, 0, 1'b0, 25'h1ABCDEF);
    // three wait states in every ACCESS
    issue_cmd(2'd2, 8'h5A, 16'h1234, 16'h00FF, 3, 0, NO_ERR, 0, 1'b0, 25'h1ABCDEF);
    // three empty STATUS reads before data is ready
    issue_cmd(2'd1, 8'h11, 16'hBEEF, 16'h0001, 0, 3, NO_ERR, 0, 1'b0, 25'h0123456);
    // STATUS never non-empty: poll timeout
    issue_cmd(2'd3, 8'hC3, 16'hFFFF, 16'hFFFF, 1, NO_ERR, NO_ERR, 0, 1'b0, 25'h1555555);
    // slave error on the DATA_1 write
    issue_cmd(2'd0, 8'h01, 16'h0F0F, 16'hF0F0, 0, 0, 1, 0, 1'b0, 25'h0000001);
    // response back-pressure with cmd_valid held high
    issue_cmd(2'd1, 8'hA5, 16'h8000, 16'h7FFF, 0, 1, NO_ERR, 5, 1'b1, 25'h1FFFFFF);

    for (int n = 0; n < 40; n++) begin
      ei = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 8)) : NO_ERR;
      issue_cmd(OW'($urandom), IW'($urandom), DW'($urandom), DW'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), ei,
                int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), RW'($urandom));
    end

    // reset during the CTRL write ACCESS phase
    begin
      int budget;
      cfg_wait = 3; cfg_n_empty = 0; cfg_err_idx = NO_ERR; cfg_result = 25'h0ABCDE;
      xfer_idx = 0; status_reads = 0;
      bus_q.push_back({1'b1, ADDR_DATA0, 32'h0000_0042});
      bus_q.push_back({1'b1, ADDR_DATA1, 32'h0000_0043});
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_id = 8'h77; cmd_a = 16'h0042; cmd_b = 16'h0043;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      budget = 0;
      while (!(psel && penable && pwrite && paddr == ADDR_CTRL) && budget < 200) begin
        @(negedge clk);
        budget++;
      end
      if (budget >= 200) flag_fail("ctrl_access_not_reached");
      #2 rst_n = 1'b0;
      #1;
      check("midreset_psel", psel, 1'b0);
      check("midreset_penable", penable, 1'b0);
      check("midreset_cmd_ready", cmd_ready, 1'b1);
      check("midreset_rsp_valid", rsp_valid, 1'b0);
      check("midreset_paddr", paddr, 32'h0);
      check("midreset_bus_q_drained", 128'(bus_q.size()), 128'(0));
      clear_expectations();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
    end

    // normal operation resumes after the reset
    issue_cmd(2'd2, 8'h5A, 16'h1234, 16'h00FF, 0, 0, NO_ERR, 0, 1'b0, 25'h1ABCDEF);
    repeat (3) @(negedge clk);

    check("final_exp_q_empty", 128'(exp_q.size()), 128'(0));
    check("final_bus_q_empty", 128'(bus_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule
